// File: rtl/regfile_bist_pkg.sv
// Shared types and constants for the register-file built-in self-test.
package regfile_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_SEED = 32'hA5A5A5A5;
    localparam int          NUM_REGS     = 32;
    localparam int          ERR_MAX      = 63;
    localparam int          IDX_W        = 5;
    localparam int          ERR_W        = 6;
    localparam int          DATA_W       = 32;

endpackage

// File: rtl/regfile_bist_pattern.sv
// Combinational pattern generator: the write pattern for a register, or the
// value a healthy regfile must return for it (register 0 always reads zero).
module regfile_bist_pattern
    import regfile_bist_pkg::*;
#(
    parameter logic [31:0] SEED = DEFAULT_SEED
) (
    input  logic [IDX_W-1:0]  i_idx,
    input  logic              i_phase,
    input  logic              i_expected,
    output logic [DATA_W-1:0] o_value
);

    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_pat;

    assign w_base  = SEED ^ {{(DATA_W-IDX_W){1'b0}}, i_idx};
    assign w_pat   = i_phase ? ~w_base : w_base;
    assign o_value = (i_expected && (i_idx == '0)) ? '0 : w_pat;

endmodule

// File: rtl/regfile_bist.sv
// Self-test driver for a 32x32 register file: writes a seeded pattern and its
// inverse, reads each register back on both ports and counts mismatches.
module regfile_bist
    import regfile_bist_pkg::*;
#(
    parameter int          READ_LAT = 1,
    parameter logic [31:0] SEED     = DEFAULT_SEED
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_test,
    output logic              o_t_ctrl_writeEnable,
    output logic [IDX_W-1:0]  o_t_ctrl_writeReg,
    output logic [DATA_W-1:0] o_t_data_writeReg,
    output logic [IDX_W-1:0]  o_t_ctrl_readRegA,
    output logic [IDX_W-1:0]  o_t_ctrl_readRegB,
    input  logic [DATA_W-1:0] i_t_data_readRegA,
    input  logic [DATA_W-1:0] i_t_data_readRegB,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [ERR_W-1:0]  o_err_count,
    output logic [IDX_W-1:0]  o_first_fail_reg,
    output state_t            o_dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [2:0]       LAT_LAST = 3'(READ_LAT);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_phase;
    logic [IDX_W-1:0]  r_idx;
    logic [2:0]        r_lat;
    logic [ERR_W-1:0]  r_err;
    logic [IDX_W-1:0]  r_first_fail;

    logic              w_in_write;
    logic              w_in_read;
    logic              w_cmp;
    logic              w_miss_a;
    logic              w_miss_b;
    logic [IDX_W-1:0]  w_idx_b;
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_exp_b;
    logic [ERR_W:0]    w_err_sum;
    logic [ERR_W-1:0]  w_err_next;

    assign w_in_write = (r_state == ST_WRITE);
    assign w_in_read  = (r_state == ST_READ);
    assign w_cmp      = w_in_read && (r_lat == LAT_LAST);
    assign w_idx_b    = ~r_idx;

    // Port A's generator yields write data in WRITE and the expected readback in READ.
    regfile_bist_pattern #(.SEED(SEED)) u_pat_a (
        .i_idx      (r_idx),
        .i_phase    (r_phase),
        .i_expected (w_in_read),
        .o_value    (w_val_a)
    );

    regfile_bist_pattern #(.SEED(SEED)) u_pat_b (
        .i_idx      (w_idx_b),
        .i_phase    (r_phase),
        .i_expected (1'b1),
        .o_value    (w_exp_b)
    );

    assign w_miss_a   = (i_t_data_readRegA != w_val_a);
    assign w_miss_b   = (i_t_data_readRegB != w_exp_b);
    assign w_err_sum  = (ERR_W+1)'(r_err) + (ERR_W+1)'(w_miss_a) + (ERR_W+1)'(w_miss_b);
    assign w_err_next = (w_err_sum > (ERR_W+1)'(ERR_MAX)) ? ERR_W'(ERR_MAX) : w_err_sum[ERR_W-1:0];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) w_next_state = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_idx == LAST_IDX) w_next_state = ST_READ;
            end
            ST_READ: begin
                if (w_cmp && (r_idx == LAST_IDX)) w_next_state = r_phase ? ST_DONE : ST_WRITE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_phase      <= 1'b0;
            r_idx        <= '0;
            r_lat        <= '0;
            r_err        <= '0;
            r_first_fail <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_phase      <= 1'b0;
                        r_idx        <= '0;
                        r_lat        <= '0;
                        r_err        <= '0;
                        r_first_fail <= '0;
                    end
                end
                ST_WRITE: begin
                    r_lat <= '0;
                    r_idx <= r_idx + 1'b1;
                end
                ST_READ: begin
                    if (w_cmp) begin
                        r_lat <= '0;
                        r_idx <= r_idx + 1'b1;
                        r_err <= w_err_next;
                        // Only the very first mismatch is recorded; port A has priority.
                        if ((r_err == '0) && (w_miss_a || w_miss_b))
                            r_first_fail <= w_miss_a ? r_idx : w_idx_b;
                        if (r_idx == LAST_IDX) r_phase <= 1'b1;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_test               = w_in_write || w_in_read;
    assign o_busy               = w_in_write || w_in_read;
    assign o_t_ctrl_writeEnable = w_in_write;
    assign o_t_ctrl_writeReg    = w_in_write ? r_idx : '0;
    assign o_t_data_writeReg    = w_in_write ? w_val_a : '0;
    assign o_t_ctrl_readRegA    = w_in_read ? r_idx : '0;
    assign o_t_ctrl_readRegB    = w_in_read ? w_idx_b : '0;
    assign o_done               = (r_state == ST_DONE);
    assign o_pass               = o_done && (r_err == '0);
    assign o_err_count          = r_err;
    assign o_first_fail_reg     = r_first_fail;
    assign o_dbg_state          = r_state;

endmodule

// File: doc/regfile_bist.md
REGFILE_BIST -- requirements
Module: regfile_bist

Interface
REQ-001 Parameter: READ_LAT, 1, number of cycles a read address is held before the readback is compared (range 1-4).
REQ-002 Parameter: SEED, 32'hA5A5A5A5, base data pattern.
REQ-003 clock  in  1  single clock; the same clock that drives the regfile under test.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  single-cycle request to run the self-test.
REQ-006 test  out  1  selects the driver's ports over the processor's ports at the regfile input muxes.
REQ-007 t_ctrl_writeEnable  out  1  regfile write enable.
REQ-008 t_ctrl_writeReg  out  5  regfile write index.
REQ-009 t_data_writeReg  out  32  regfile write data.
REQ-010 t_ctrl_readRegA / t_ctrl_readRegB  out  5 each  regfile read indices.
REQ-011 t_data_readRegA / t_data_readRegB  in  32 each  combinational regfile read data.
REQ-012 busy  out  1  test in progress.
REQ-013 done  out  1  test complete; held until the next accepted start or reset.
REQ-014 pass  out  1  equals done AND err_count==0.
REQ-015 err_count  out  6  number of port mismatches, saturating at 63.
REQ-016 first_fail_reg  out  5  index of the first register that mismatched; valid only when err_count!=0.

Function
REQ-017 Pattern: pat(r,p) = SEED XOR {27'b0,r} when p=0, and its bitwise inverse when p=1.
REQ-018 Expected value: exp(0)=0 in both phases; exp(r)=pat(r,p) for r!=0.
REQ-019 FSM states: IDLE, WRITE, READ, DONE.
REQ-020 IDLE or DONE with start=1: clear err_count and first_fail_reg, set phase=0 and idx=0, deassert done, go to WRITE.
REQ-021 start SHALL be ignored in WRITE and READ.
REQ-022 WRITE, one register per cycle: test=1, writeEnable=1, writeReg=idx, writeData=pat(idx,phase); all 32 registers (0-31) are written. After idx=31, go to READ with idx=0.
REQ-023 READ, READ_LAT+1 cycles per register: test=1, writeEnable=0, readRegA=idx, readRegB=~idx; compare on the final cycle of each register.
REQ-024 Comparison: A against exp(idx) and B against exp(~idx). Each mismatching port adds 1 to err_count, so one cycle can add 0, 1 or 2.
REQ-025 first_fail_reg is captured on the first mismatch only. If both ports fail in that cycle, port A's index wins.
REQ-026 After idx=31 in READ: if phase=0, go to WRITE with phase=1 and idx=0; otherwise go to DONE.
REQ-027 Latency: start sampled in cycle n gives the first WRITE in cycle n+1 and done=1 from cycle n+1+2*(32+32*(READ_LAT+1)). With READ_LAT=1 that is cycle n+193.
REQ-028 busy=1 exactly in WRITE and READ. test=0 and writeEnable=0 in IDLE and DONE.
REQ-029 idx wraps 31 to 0 only at the phase transitions defined above. err_count saturates at 63 and never wraps.

Reset
REQ-030 reset low SHALL immediately force IDLE and drive all outputs to 0: test, writeEnable, busy, done, pass, err_count, first_fail_reg, all indices and data. This holds mid-WRITE or mid-READ.
REQ-031 After reset release the block SHALL stay in IDLE until start=1.

Structure
REQ-032 Package regfile_bist_pkg SHALL hold the state enum, the default SEED, NUM_REGS=32 and ERR_MAX=63.
REQ-033 Pattern/expected-value generation (REQ-017/018) SHALL be one combinational sub-module, regfile_bist_pattern, instantiated twice (port A, port B).
REQ-034 All state, counters and result registers SHALL be in regfile_bist; there SHALL be no other clocks and no latches.

Verification
REQ-035 Correct regfile model, READ_LAT=1, start pulse at cycle 10 -> done=1 and pass=1 at cycle 203, err_count=0.
REQ-036 Model with reg7 bit3 stuck-at-0 -> phase 0 passes; phase 1 fails on idx=7 port A and on idx=24 port B; err_count=2, first_fail_reg=7, pass=0.
REQ-037 Model where reg0 stores writes -> mismatches on idx0 port A and idx31 port B in both phases; err_count=4, first_fail_reg=0.
REQ-038 Model returning all zeros -> 62 mismatches per phase; err_count saturates at 63, first_fail_reg=31.
REQ-039 reset driven low during WRITE idx=10 -> test, writeEnable and busy go to 0 with no clock edge; no activity after release until start.
REQ-040 start pulsed while busy -> no effect. start pulsed in DONE -> done drops next cycle, err_count=0, and a full rerun completes in the same cycle count.
